// File: rtl/shift_normalizer_if.sv
// Handshake bundle for shift_normalizer: operand in, normalized result out.
// The slave modport is the normalizer; the master modport is the producer/consumer side.
interface shift_normalizer_if #(
  parameter int unsigned WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           data_in;
  logic                       shift_direction;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           data_out;
  logic [$clog2(WIDTH)-1:0]   shift_amount;
  logic                       zero;

  modport master (
    output in_valid,
    input  in_ready,
    output data_in,
    output shift_direction,
    input  out_valid,
    output out_ready,
    input  data_out,
    input  shift_amount,
    input  zero
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  data_in,
    input  shift_direction,
    output out_valid,
    input  out_ready,
    output data_out,
    output shift_amount,
    output zero
  );
endinterface

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: shifts one bit per cycle until the MSB (left) or LSB (right)
// is set, reporting the distance shifted; all-zero operands finish immediately.
module shift_normalizer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  shift_normalizer_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic             mode_q;
  logic [CW-1:0]    count_q;
  logic             zero_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] shifted;
  logic             shifted_hit;
  logic             in_zero;
  logic             in_hit;
  logic             accept;

  always_comb begin
    shifted     = mode_q ? (work_q << 1) : (work_q >> 1);
    shifted_hit = mode_q ? shifted[WIDTH-1] : shifted[0];
    in_zero     = (bus.data_in == '0);
    in_hit      = bus.shift_direction ? bus.data_in[WIDTH-1] : bus.data_in[0];
    accept      = bus.in_valid && (state_q == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      mode_q      <= 1'b0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            work_q  <= bus.data_in;
            mode_q  <= bus.shift_direction;
            count_q <= '0;
            zero_q  <= in_zero;
            // Already normalized (or nothing to normalize): skip straight to the result.
            if (in_zero || in_hit) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          work_q  <= shifted;
          count_q <= count_q + CW'(1);
          if (shifted_hit) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.out_valid    = out_valid_q;
  assign bus.data_out     = work_q;
  assign bus.shift_amount = count_q;
  assign bus.zero         = zero_q;
endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer (WIDTH = 8): directed operands, queued expectations,
// and a negedge monitor that checks results, latency, stability under backpressure.
module tb_shift_normalizer;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] data;
    int           amt;
    logic         zero;
    int           lat;
  } exp_t;

  logic clk;
  logic rst;
  shift_normalizer_if #(.WIDTH(W)) bus ();

  shift_normalizer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   accept_edge = 0;
  int   hs_edge  = 0;
  bit   seen_valid = 0;
  bit   check_b2b  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks = n_checks + 1;
    if (act !== expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: samples mid-cycle, when inputs and registered outputs are both settled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen_valid = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        accept_edge = cyc + 1;
        n_acc = n_acc + 1;
        if (check_b2b) begin
          check("b2b_accept_edge", accept_edge, hs_edge + 1);
          check_b2b = 0;
        end
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_checks = n_checks + 1;
          n_fail = n_fail + 1;
          $display("FAIL unexpected_out_valid: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb[0];
          if (!seen_valid) begin
            seen_valid = 1;
            check("latency", cyc - accept_edge + 1, e.lat);
          end
          check("data_out", int'(bus.data_out), int'(e.data));
          check("shift_amount", int'(bus.shift_amount), e.amt);
          check("zero", int'(bus.zero), int'(e.zero));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            hs_edge = cyc + 1;
            seen_valid = 0;
          end else begin
            check("in_ready_in_done", int'(bus.in_ready), 0);
          end
        end
      end
    end
  end

  task automatic wait_acc(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_acc >= target) begin
        ok = 1;
        break;
      end
    end
    check("accept_timeout", int'(ok), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_timeout", sb.size(), 0);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
  task automatic run_op(input logic [W-1:0] d, input logic dir, input logic [W-1:0] xd,
                        input int xa, input logic xz, input int xl);
    exp_t e;
    int   target;
    e.data = xd; e.amt = xa; e.zero = xz; e.lat = xl;
    sb.push_back(e);
    target = n_acc + 1;
    bus.data_in = d;
    bus.shift_direction = dir;
    bus.in_valid = 1'b1;
    wait_acc(target);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1;
        break;
      end
    end
    check("out_valid_timeout", int'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   target;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.shift_direction = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_data_out", int'(bus.data_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Main function and boundaries.
    run_op(8'h13, 1'b1, 8'h98, 3, 1'b0, 4);
    run_op(8'h28, 1'b0, 8'h05, 3, 1'b0, 4);
    run_op(8'h80, 1'b1, 8'h80, 0, 1'b0, 1);
    run_op(8'h01, 1'b1, 8'h80, 7, 1'b0, 8);
    run_op(8'h80, 1'b0, 8'h01, 7, 1'b0, 8);
    run_op(8'h00, 1'b1, 8'h00, 0, 1'b1, 1);
    run_op(8'h00, 1'b0, 8'h00, 0, 1'b1, 1);
    run_op(8'h06, 1'b0, 8'h03, 1, 1'b0, 2);
    run_op(8'h01, 1'b0, 8'h01, 0, 1'b0, 1);

    // Backpressure with a second operand waiting on the input.
    bus.out_ready = 1'b0;
    e.data = 8'h98; e.amt = 3; e.zero = 1'b0; e.lat = 4;
    sb.push_back(e);
    e.data = 8'hFF; e.amt = 0; e.zero = 1'b0; e.lat = 1;
    sb.push_back(e);
    target = n_acc + 1;
    bus.data_in = 8'h13;
    bus.shift_direction = 1'b1;
    bus.in_valid = 1'b1;
    wait_acc(target);
    @(posedge clk);
    #1 bus.data_in = 8'hFF;
    wait_out_valid();
    repeat (5) @(posedge clk);
    #1;
    check_b2b = 1;
    bus.out_ready = 1'b1;
    wait_acc(target + 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_drain();
    check("b2b_flag_consumed", int'(check_b2b), 0);

    // Reset while holding a result in DONE; operand offered during reset must be ignored.
    bus.out_ready = 1'b0;
    run_op_hold: begin
      e.data = 8'h98; e.amt = 3; e.zero = 1'b0; e.lat = 4;
      sb.push_back(e);
      target = n_acc + 1;
      bus.data_in = 8'h13;
      bus.shift_direction = 1'b1;
      bus.in_valid = 1'b1;
      wait_acc(target);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_out_valid();
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    bus.in_valid = 1'b1;
    bus.data_in = 8'h55;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_data_out", int'(bus.data_out), 0);
    check("midrst_shift_amount", int'(bus.shift_amount), 0);
    check("midrst_zero", int'(bus.zero), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_after", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // Reset on the third SHIFT cycle of a long operation: no result may appear.
    target = n_acc + 1;
    bus.data_in = 8'h01;
    bus.shift_direction = 1'b1;
    bus.in_valid = 1'b1;
    wait_acc(target);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    run_op(8'h04, 1'b0, 8'h01, 2, 1'b0, 3);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
